dual_src_write_sequencer: RTL and testbench

- Upstream feeder for the two-write-port 16-bit holding register stage.
- Accepts words from two independent producers over valid/ready handshakes and buffers each in a small per-source FIFO.
- Issues them to the register stage as one-hot write strobes w1/w2 with data on ip1/ip2, alternating sources round-robin.
- Interleaves read strobes r on request, so the downstream stage never sees w1 and w2 together.

---
 rtl/dual_src_write_sequencer_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/dual_src_write_sequencer.sv | 134 +++++++++++++
 tb/tb_dual_src_write_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_src_write_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dual_src_write_sequencer_pkg
//   Shared definitions for the dual-source write sequencer:
//     - WIDTH_DEF      default data word width (matches the register stage)
//     - src_e          source encoding (SRC1 / SRC2)
//     - LAST_SRC_RST   reset value of the round-robin pointer
//     - issue_e        per-cycle issue decision
//     - pick_issue()   priority/round-robin arbitration rule
// -----------------------------------------------------------------------------
package dual_src_write_sequencer_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_e;

  // Source 2 counts as "last served" out of reset so source 1 wins the first tie.
  localparam src_e LAST_SRC_RST = SRC2;

  typedef enum logic [1:0] {
    ISSUE_NONE,
    ISSUE_READ,
    ISSUE_S1,
    ISSUE_S2
  } issue_e;

  // Reads beat writes; on a write tie the source not served last goes next.
  function automatic issue_e pick_issue(input logic pend,
                                        input logic ne1,
                                        input logic ne2,
                                        input src_e last);
    if (pend)        return ISSUE_READ;
    if (ne1 && ne2)  return (last == SRC1) ? ISSUE_S2 : ISSUE_S1;
    if (ne1)         return ISSUE_S1;
    if (ne2)         return ISSUE_S2;
    return ISSUE_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Small synchronous FIFO with a combinational head (first-word fall-through).
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; empties the FIFO
//     push   write din at the edge (ignored when full)
//     din    write data
//     pop    drop the head at the edge (ignored when empty)
//     dout   current head word, combinational
//     full   count == DEPTH
//     empty  count == 0
//   Simultaneous push and pop are both honoured and leave the count unchanged.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  // Pointers wrap naturally because DEPTH is a power of two.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is never read before it
  // has been written, since count gates dout usage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dual_src_write_sequencer.sv
// -----------------------------------------------------------------------------
// dual_src_write_sequencer
//   Feeds a two-write-port holding register stage from two independent
//   producers. Each producer has its own small FIFO; buffered words are issued
//   one at a time as one-hot write strobes, alternating sources round-robin,
//   with read strobes interleaved on request (reads have priority).
//   Ports:
//     clk, reset              clock; synchronous active-high reset
//     s1_data/valid/ready     source 1 handshake (ready low during reset)
//     s2_data/valid/ready     source 2 handshake (ready low during reset)
//     rd_req                  single-cycle request for one read strobe
//     ip1, ip2                write data, held between writes
//     w1, w2, r               registered one-cycle strobes, mutually exclusive
//     busy                    a FIFO holds data or a read is pending
// -----------------------------------------------------------------------------
module dual_src_write_sequencer
  import dual_src_write_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [WIDTH-1:0] s2_data,
  input  logic             s2_valid,
  output logic             s2_ready,
  input  logic             rd_req,
  output logic [WIDTH-1:0] ip1,
  output logic [WIDTH-1:0] ip2,
  output logic             w1,
  output logic             w2,
  output logic             r,
  output logic             busy
);

  logic             f1_full, f1_empty, f2_full, f2_empty;
  logic [WIDTH-1:0] f1_dout, f2_dout;
  logic             pop1, pop2;

  logic             pend_q, pend_d;
  src_e             last_src_q, last_src_d;
  logic             w1_q, w1_d, w2_q, w2_d, r_q, r_d;
  logic [WIDTH-1:0] ip1_q, ip1_d, ip2_q, ip2_d;
  issue_e           issue;

  // Ready depends on occupancy only: a full FIFO does not accept even when
  // its head is leaving this cycle.
  assign s1_ready = !reset && !f1_full;
  assign s2_ready = !reset && !f2_full;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid && s1_ready),
    .din   (s1_data),
    .pop   (pop1),
    .dout  (f1_dout),
    .full  (f1_full),
    .empty (f1_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid && s2_ready),
    .din   (s2_data),
    .pop   (pop2),
    .dout  (f2_dout),
    .full  (f2_full),
    .empty (f2_empty)
  );

  assign issue = pick_issue(pend_q, !f1_empty, !f2_empty, last_src_q);

  always_comb begin
    last_src_d = last_src_q;
    w1_d       = 1'b0;
    w2_d       = 1'b0;
    r_d        = 1'b0;
    ip1_d      = ip1_q;
    ip2_d      = ip2_q;
    pop1       = 1'b0;
    pop2       = 1'b0;
    // A request arriving while a read is already pending merges into it.
    pend_d     = pend_q ? 1'b0 : rd_req;
    case (issue)
      ISSUE_READ: r_d = 1'b1;
      ISSUE_S1: begin
        pop1       = 1'b1;
        w1_d       = 1'b1;
        ip1_d      = f1_dout;
        last_src_d = SRC1;
      end
      ISSUE_S2: begin
        pop2       = 1'b1;
        w2_d       = 1'b1;
        ip2_d      = f2_dout;
        last_src_d = SRC2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      last_src_q <= LAST_SRC_RST;
      w1_q       <= 1'b0;
      w2_q       <= 1'b0;
      r_q        <= 1'b0;
      ip1_q      <= '0;
      ip2_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      last_src_q <= last_src_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      r_q        <= r_d;
      ip1_q      <= ip1_d;
      ip2_q      <= ip2_d;
    end
  end

  assign w1   = w1_q;
  assign w2   = w2_q;
  assign r    = r_q;
  assign ip1  = ip1_q;
  assign ip2  = ip2_q;
  assign busy = !f1_empty || !f2_empty || pend_q;

endmodule

// File: tb/tb_dual_src_write_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dual_src_write_sequencer: a table of hand-derived
// vectors, hand-written corner sequences, and random traffic compared against
// a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_dual_src_write_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, s1_valid, s2_valid, rd_req;
  logic [15:0] s1_data, s2_data, ip1, ip2;
  logic        s1_ready, s2_ready, w1, w2, r, busy;

  int errors = 0;
  int checks = 0;

  dual_src_write_sequencer #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .s1_data  (s1_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s2_data  (s2_data),
    .s2_valid (s2_valid),
    .s2_ready (s2_ready),
    .rd_req   (rd_req),
    .ip1      (ip1),
    .ip2      (ip2),
    .w1       (w1),
    .w2       (w2),
    .r        (r),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_q1[$];
  logic [15:0] m_q2[$];
  bit          m_pend;
  int          m_last;      // 1 or 2: source served most recently
  bit          m_w1, m_w2, m_r;
  logic [15:0] m_ip1, m_ip2;
  bit          m_rdy1, m_rdy2;
  bit          acc1, acc2;
  logic        d_rdy1, d_rdy2;

  function automatic bit m_busy();
    return (m_q1.size() > 0) || (m_q2.size() > 0) || m_pend;
  endfunction

  task automatic model_step(input bit rst, input bit s1v, input logic [15:0] s1d,
                            input bit s2v, input logic [15:0] s2d, input bit rdq);
    m_rdy1 = !rst && (m_q1.size() < DEPTH);
    m_rdy2 = !rst && (m_q2.size() < DEPTH);
    m_w1 = 0; m_w2 = 0; m_r = 0;
    if (rst) begin
      m_q1.delete(); m_q2.delete();
      m_pend = 0; m_last = 2; m_ip1 = '0; m_ip2 = '0;
      acc1 = 0; acc2 = 0;
    end else begin
      acc1 = s1v && m_rdy1;
      acc2 = s2v && m_rdy2;
      if (m_pend) begin
        m_r = 1;
        m_pend = 0;
      end else begin
        m_pend = rdq;
        if (m_q1.size() > 0 && (m_q2.size() == 0 || m_last == 2)) begin
          m_w1 = 1; m_ip1 = m_q1.pop_front(); m_last = 1;
        end else if (m_q2.size() > 0) begin
          m_w2 = 1; m_ip2 = m_q2.pop_front(); m_last = 2;
        end
      end
      if (acc1) m_q1.push_back(s1d);
      if (acc2) m_q2.push_back(s2d);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample combinational ready, advance model and DUT.
  task automatic cycle(input bit rst, input bit s1v, input logic [15:0] s1d,
                       input bit s2v, input logic [15:0] s2d, input bit rdq);
    reset = rst; s1_valid = s1v; s1_data = s1d;
    s2_valid = s2v; s2_data = s2d; rd_req = rdq;
    #1;
    d_rdy1 = s1_ready;
    d_rdy2 = s2_ready;
    model_step(rst, s1v, s1d, s2v, s2d, rdq);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".s1_ready"}, d_rdy1, m_rdy1);
    check({tag, ".s2_ready"}, d_rdy2, m_rdy2);
    check({tag, ".w1"}, w1, m_w1);
    check({tag, ".w2"}, w2, m_w2);
    check({tag, ".r"}, r, m_r);
    check({tag, ".ip1"}, ip1, m_ip1);
    check({tag, ".ip2"}, ip2, m_ip2);
    check({tag, ".busy"}, busy, m_busy());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        s1v;
    logic [15:0] s1d;
    logic        s2v;
    logic [15:0] s2d;
    logic        rdq;
    logic        rdy1;
    logic        rdy2;
    logic        w1;
    logic        w2;
    logic        r;
    logic [15:0] ip1;
    logic [15:0] ip2;
    logic        busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [15:0] words[5];
    logic [15:0] issued[$];
    int          sent;
    int          strobes;
    bit          seen_full;

    reset = 1'b1; s1_valid = 1'b0; s2_valid = 1'b0; rd_req = 1'b0;
    s1_data = '0; s2_data = '0;

    //         rst   s1v   s1d       s2v   s2d       rdq  | rdy1  rdy2  w1    w2    r     ip1       ip2       busy
    tbl[0]  = '{1'b1, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h1111, 1'b1, 16'h269A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 16'h2222, 1'b1, 16'h6FA7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h269A, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h269A, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 16'h6FA7, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h6FA7, 1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(tbl[i].rst, tbl[i].s1v, tbl[i].s1d, tbl[i].s2v, tbl[i].s2d, tbl[i].rdq);
      check({t, ".s1_ready"}, d_rdy1, tbl[i].rdy1);
      check({t, ".s2_ready"}, d_rdy2, tbl[i].rdy2);
      check({t, ".w1"}, w1, tbl[i].w1);
      check({t, ".w2"}, w2, tbl[i].w2);
      check({t, ".r"}, r, tbl[i].r);
      check({t, ".ip1"}, ip1, tbl[i].ip1);
      check({t, ".ip2"}, ip2, tbl[i].ip2);
      check({t, ".busy"}, busy, tbl[i].busy);
      check({t, ".onehot"}, 32'(w1) + 32'(w2) + 32'(r) <= 1, 1);
    end

    // Read priority: rd_req with a push, then a second rd_req while pending.
    cycle(0, 1, 16'hBEEF, 0, 16'h0, 1);
    check_model("rdpri0");
    check("rdpri0.r_none", r, 0);
    cycle(0, 0, 16'h0, 0, 16'h0, 1);
    check_model("rdpri1");
    check("rdpri1.r_first", r, 1);
    check("rdpri1.w1_held", w1, 0);
    idle();
    check_model("rdpri2");
    check("rdpri2.w1_next", w1, 1);
    check("rdpri2.ip1", ip1, 16'hBEEF);
    check("rdpri2.r_once", r, 0);
    idle();
    check("rdpri3.r_once", r, 0);

    // Full FIFO on source 2 while reads are held requested, then drain.
    words = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'h0000};
    sent = 0;
    seen_full = 0;
    issued.delete();
    for (int c = 0; c < 8; c++) begin
      bit v;
      v = (sent < 4);
      cycle(0, 0, 16'h0, v, words[sent], 1);
      check_model($sformatf("full%0d", c));
      if (v && !d_rdy2) seen_full = 1;
      if (acc2) sent++;
      if (w2) issued.push_back(ip2);
    end
    for (int c = 0; c < 8; c++) begin
      idle();
      check_model($sformatf("drain%0d", c));
      if (w2) issued.push_back(ip2);
    end
    check("full.ready_low_seen", seen_full, 1);
    check("full.issued_count", issued.size(), sent);
    for (int i = 0; i < issued.size() && i < 4; i++)
      check($sformatf("full.order%0d", i), issued[i], words[i]);

    // Mid-operation reset discards buffered words and resets arbitration.
    cycle(0, 1, 16'hD001, 1, 16'hE001, 0);
    cycle(0, 1, 16'hD002, 1, 16'hE002, 0);
    cycle(0, 1, 16'hD003, 1, 16'hE003, 1);
    check_model("midrst.pre");
    cycle(1, 0, 16'h0, 0, 16'h0, 0);
    check_model("midrst.rst");
    check("midrst.busy", busy, 0);
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      idle();
      check_model($sformatf("midrst.idle%0d", c));
      strobes += 32'(w1) + 32'(w2) + 32'(r);
    end
    check("midrst.no_stale", strobes, 0);
    cycle(0, 1, 16'hF001, 1, 16'hF002, 0);
    idle();
    check_model("midrst.tie");
    check("midrst.tie_w1", w1, 1);
    check("midrst.tie_ip1", ip1, 16'hF001);
    idle();
    check("midrst.next_w2", w2, 1);
    check("midrst.next_ip2", ip2, 16'hF002);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bit rst_i, v1, v2, rq;
      rst_i = ($urandom_range(0, 99) == 0);
      v1 = $urandom_range(0, 1);
      v2 = $urandom_range(0, 1);
      rq = ($urandom_range(0, 9) == 0);
      cycle(rst_i, v1, 16'($urandom), v2, 16'($urandom), rq);
      check_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
